// File: rtl/mmio_responder_pkg.sv
// Register map, control-bit positions and reset values for the MMIO responder window.
// Also provides the window-decode helper shared by the top level.
package mmio_responder_pkg;

  localparam logic [3:0] OffLed0     = 4'h0;
  localparam logic [3:0] OffLed1     = 4'h1;
  localparam logic [3:0] OffLed2     = 4'h2;
  localparam logic [3:0] OffLed3     = 4'h3;
  localparam logic [3:0] OffTmrLo    = 4'h4;
  localparam logic [3:0] OffTmrHi    = 4'h5;
  localparam logic [3:0] OffPrescale = 4'h6;
  localparam logic [3:0] OffTmrCtrl  = 4'h7;
  localparam logic [3:0] OffBtnState = 4'h8;
  localparam logic [3:0] OffBtnEvt   = 4'h9;
  localparam logic [3:0] OffScratch  = 4'hA;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlClrBit = 1;

  localparam logic [7:0] LedRst      = 8'h00;
  localparam logic [7:0] PrescaleRst = 8'h00;
  localparam logic [7:0] TmrCtrlRst  = 8'h01;
  localparam logic [7:0] ScratchRst  = 8'h00;

  function automatic logic in_window(input logic [7:0] a, input logic [7:0] base);
    return a[7:4] == base[7:4];
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-stage synchroniser for asynchronous button inputs with a rising-edge detector.
module btn_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  always_comb begin
    q    = sync_q[STAGES-1];
    rise = q & ~prev_q;
  end

endmodule

// File: rtl/mmio_responder.sv
// 16-byte MMIO window: LED registers, prescaled 16-bit timer with HI shadow, button
// levels/events and a scratch register. Read timing matches the block RAM.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hF0,
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         addr,
  input  logic               wr_enable,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               hit,
  output logic [7:0]         leds1,
  output logic [7:0]         leds2,
  output logic [7:0]         leds3,
  output logic [7:0]         leds4,
  input  logic [NUM_BTN-1:0] btn
);

  logic [3:0][7:0]     led_q;
  logic [7:0]          prescale_q;
  logic                en_q;
  logic [7:0]          pc_q, pc_d;
  logic [15:0]         tmr_q, tmr_d;
  logic [7:0]          hi_q;
  logic [7:0]          scratch_q;
  logic [NUM_BTN-1:0]  evt_q, evt_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                hit_q;

  logic                in_win, wr, rd_lo, clr, tick;
  logic [3:0]          off;
  logic [7:0]          rd_val;
  logic [NUM_BTN-1:0]  btn_lvl, btn_rise, w1c;

  btn_sync #(
    .WIDTH  (NUM_BTN),
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (btn),
    .q    (btn_lvl),
    .rise (btn_rise)
  );

  always_comb begin
    in_win = in_window(addr, BASE_ADDR);
    off    = addr[3:0];
    wr     = in_win && wr_enable;
    rd_lo  = in_win && !wr_enable && (off == OffTmrLo);
    clr    = wr && (off == OffTmrCtrl) && wdata[CtrlClrBit];
    w1c    = (wr && (off == OffBtnEvt)) ? wdata[NUM_BTN-1:0] : '0;
    // A newly detected edge wins over a simultaneous write-one-to-clear.
    evt_d  = (evt_q & ~w1c) | btn_rise;
  end

  // Timer next state: clear beats prescale reload, which beats normal counting.
  always_comb begin
    pc_d  = pc_q;
    tmr_d = tmr_q;
    tick  = en_q && (pc_q == prescale_q);
    if (en_q) begin
      if (tick) begin
        pc_d  = 8'd0;
        tmr_d = tmr_q + 16'd1;
      end else begin
        pc_d  = pc_q + 8'd1;
      end
    end
    if (wr && (off == OffPrescale)) begin
      pc_d = 8'd0;
    end
    if (clr) begin
      pc_d  = 8'd0;
      tmr_d = 16'd0;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (off)
      OffLed0:     rd_val = led_q[0];
      OffLed1:     rd_val = led_q[1];
      OffLed2:     rd_val = led_q[2];
      OffLed3:     rd_val = led_q[3];
      OffTmrLo:    rd_val = tmr_q[7:0];
      OffTmrHi:    rd_val = hi_q;
      OffPrescale: rd_val = prescale_q;
      OffTmrCtrl:  rd_val[CtrlEnBit] = en_q;
      OffBtnState: rd_val[NUM_BTN-1:0] = btn_lvl;
      OffBtnEvt:   rd_val[NUM_BTN-1:0] = evt_q;
      OffScratch:  rd_val = scratch_q;
      default:     rd_val = 8'h00;
    endcase
    rdata_d = (in_win && !wr_enable) ? rd_val : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= {4{LedRst}};
      prescale_q <= PrescaleRst;
      en_q       <= TmrCtrlRst[CtrlEnBit];
      pc_q       <= 8'd0;
      tmr_q      <= 16'd0;
      hi_q       <= 8'h00;
      scratch_q  <= ScratchRst;
      evt_q      <= '0;
      rdata_q    <= 8'h00;
      hit_q      <= 1'b0;
    end else begin
      hit_q   <= in_win;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      tmr_q   <= tmr_d;
      evt_q   <= evt_d;
      if (rd_lo) begin
        hi_q <= tmr_q[15:8];
      end
      if (wr) begin
        case (off)
          OffLed0:     led_q[0]   <= wdata;
          OffLed1:     led_q[1]   <= wdata;
          OffLed2:     led_q[2]   <= wdata;
          OffLed3:     led_q[3]   <= wdata;
          OffPrescale: prescale_q <= wdata;
          OffTmrCtrl:  en_q       <= wdata[CtrlEnBit];
          OffScratch:  scratch_q  <= wdata;
          default:     ;
        endcase
      end
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign leds1 = led_q[0];
  assign leds2 = led_q[1];
  assign leds3 = led_q[2];
  assign leds4 = led_q[3];

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: reset map, LED/scratch writes, timer, buttons, reset.
module tb_mmio_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       wr_enable;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       hit;
  logic [7:0] leds1, leds2, leds3, leds4;
  logic [3:0] btn;

  int total = 0;
  int bad   = 0;

  mmio_responder #(
    .BASE_ADDR   (8'hF0),
    .NUM_BTN     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_enable (wr_enable),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .leds1     (leds1),
    .leds2     (leds2),
    .leds3     (leds3),
    .leds4     (leds4),
    .btn       (btn)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    addr      = 8'h00;
    wr_enable = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr      = a;
    wr_enable = 1'b1;
    wdata     = d;
    cyc();
    wr_enable = 1'b0;
    addr      = 8'h00;
  endtask

  // Expected value packs {hit, rdata}; hit is expected whenever the address is in the window.
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr      = a;
    wr_enable = 1'b0;
    cyc();
    check(tag, {7'b0, hit, rdata}, {7'b0, (a[7:4] == 4'hF), exp});
    addr = 8'h00;
  endtask

  initial begin
    // Reset held for several cycles with a write presented.
    rst = 1'b1; addr = 8'hF0; wr_enable = 1'b1; wdata = 8'hEE; btn = 4'h0;
    repeat (3) cyc();
    check("rst_leds1", {8'h00, leds1}, 16'h0000);
    check("rst_hit", {15'b0, hit}, 16'h0000);
    rst = 1'b0; wr_enable = 1'b0;

    rd("rst_tmr_lo", 8'hF4, 8'h00);
    rd("rst_tmr_hi", 8'hF5, 8'h00);
    rd("rst_led0", 8'hF0, 8'h00);
    rd("rst_led1", 8'hF1, 8'h00);
    rd("rst_led2", 8'hF2, 8'h00);
    rd("rst_led3", 8'hF3, 8'h00);
    rd("rst_prescale", 8'hF6, 8'h00);
    rd("rst_tmr_ctrl", 8'hF7, 8'h01);
    rd("rst_btn_state", 8'hF8, 8'h00);
    rd("rst_btn_evt", 8'hF9, 8'h00);
    rd("rst_scratch", 8'hFA, 8'h00);
    rd("reserved_fb", 8'hFB, 8'h00);
    rd("outside_20", 8'h20, 8'h00);

    // LED, scratch and reserved writes.
    wr(8'hF2, 8'hA5);
    check("leds3_write", {8'h00, leds3}, 16'h00A5);
    check("write_hit_rdata", {7'b0, hit, rdata}, 16'h0100);
    wr(8'hFA, 8'h3C);
    wr(8'hFD, 8'hFF);
    rd("scratch_rd", 8'hFA, 8'h3C);
    rd("reserved_fd", 8'hFD, 8'h00);
    rd("led2_rd", 8'hF2, 8'hA5);
    check("other_leds", {leds1, leds2 | leds4}, 16'h0000);

    // Prescale 3: one tick every 4 clocks after a clear.
    wr(8'hF6, 8'h03);
    wr(8'hF7, 8'h03);
    idle(3);
    rd("ps3_t0", 8'hF4, 8'h00);
    rd("ps3_t1", 8'hF4, 8'h01);
    idle(2);
    rd("ps3_t1_hold", 8'hF4, 8'h01);
    rd("ps3_t2", 8'hF4, 8'h02);
    rd("ctrl_clr_reads0", 8'hF7, 8'h01);

    // HI shadow across the 0x00FF -> 0x0100 carry.
    wr(8'hF6, 8'h00);
    wr(8'hF7, 8'h03);
    idle(255);
    rd("lo_ff", 8'hF4, 8'hFF);
    rd("lo_00", 8'hF4, 8'h00);
    rd("hi_01", 8'hF5, 8'h01);

    // Wrap 0xFFFF -> 0x0000.
    wr(8'hF7, 8'h03);
    idle(65535);
    rd("wrap_lo_ff", 8'hF4, 8'hFF);
    rd("wrap_hi_ff", 8'hF5, 8'hFF);
    rd("wrap_lo_01", 8'hF4, 8'h01);
    rd("wrap_hi_00", 8'hF5, 8'h00);

    // Clear on the same edge as a tick.
    wr(8'hF6, 8'h03);
    idle(3);
    wr(8'hF7, 8'h03);
    rd("clr_beats_tick", 8'hF4, 8'h00);

    // Freeze, then resume.
    wr(8'hF7, 8'h02);
    idle(20);
    rd("frozen_lo", 8'hF4, 8'h00);
    rd("frozen_ctrl", 8'hF7, 8'h00);
    wr(8'hF7, 8'h01);
    idle(4);
    rd("resumed_lo", 8'hF4, 8'h01);
    rd("resumed_ctrl", 8'hF7, 8'h01);

    // One-clock pulse on btn[1].
    btn = 4'h2;
    cyc();
    btn = 4'h0;
    rd("btn_state_e2", 8'hF8, 8'h00);
    rd("btn_state_e3", 8'hF8, 8'h02);
    rd("btn_evt_set", 8'hF9, 8'h02);
    rd("btn_state_gone", 8'hF8, 8'h00);
    wr(8'hF9, 8'h02);
    rd("btn_evt_w1c", 8'hF9, 8'h00);

    // W1C on the edge a new rising edge is detected: set wins.
    btn = 4'h2;
    cyc();
    cyc();
    wr(8'hF9, 8'h02);
    rd("btn_set_wins", 8'hF9, 8'h02);
    rd("btn_state_held", 8'hF8, 8'h02);
    wr(8'hF9, 8'h02);
    rd("btn_w1c_alone", 8'hF9, 8'h00);
    btn = 4'h0;
    idle(3);
    rd("btn_fall_no_evt", 8'hF9, 8'h00);

    // Reset mid-operation with a write presented.
    btn = 4'h1;
    cyc();
    btn = 4'h0;
    idle(3);
    wr(8'hF0, 8'h55);
    check("led0_55", {8'h00, leds1}, 16'h0055);
    rd("evt_pending", 8'hF9, 8'h01);
    rst = 1'b1; addr = 8'hF1; wr_enable = 1'b1; wdata = 8'h77;
    cyc();
    check("mid_rst_leds", {leds1 | leds2, leds3 | leds4}, 16'h0000);
    check("mid_rst_hit_rdata", {7'b0, hit, rdata}, 16'h0000);
    cyc();
    rst = 1'b0; wr_enable = 1'b0;
    rd("post_rst_tmr_lo", 8'hF4, 8'h00);
    rd("post_rst_led1", 8'hF1, 8'h00);
    rd("post_rst_evt", 8'hF9, 8'h00);
    rd("post_rst_prescale", 8'hF6, 8'h00);
    rd("post_rst_ctrl", 8'hF7, 8'h01);
    rd("post_rst_scratch", 8'hFA, 8'h00);
    rd("post_rst_led2", 8'hF2, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
